// File: rtl/wbm_seq.sv
// wbm_seq: Wishbone classic master issuing single/burst read/write cycles
// with per-beat ack and ack-release timeouts.
module wbm_seq #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int LEN_WIDTH  = 8,
  parameter int TIMEOUT    = 64
) (
  input  logic                  wbm_clk_i,
  input  logic                  wbm_rst_n_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_we_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [LEN_WIDTH-1:0]  cmd_len_i,
  input  logic [DATA_WIDTH-1:0] wdat_i,
  output logic                  wdat_take_o,
  output logic [DATA_WIDTH-1:0] rdat_o,
  output logic                  rdat_valid_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic                  wbm_cyc_o,
  output logic                  wbm_stb_o,
  output logic                  wbm_we_o,
  output logic [3:0]            wbm_sel_o,
  output logic [ADDR_WIDTH-1:0] wbm_adr_o,
  output logic [DATA_WIDTH-1:0] wbm_dat_o,
  input  logic [DATA_WIDTH-1:0] wbm_dat_i,
  input  logic                  wbm_ack_i
);
  localparam int TW = $clog2(TIMEOUT) + 1;
  typedef enum logic [2:0] {IDLE, REQ, RELEASE, FINISH, ABORT} state_t;
  state_t                state_q, state_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] adr_q, adr_d;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;
  logic [DATA_WIDTH-1:0] dat_q, dat_d;
  logic [DATA_WIDTH-1:0] rdat_q, rdat_d;
  logic                  rvld_q, rvld_d;
  logic [TW-1:0]         tmr_q, tmr_d;
  logic                  take;
  always_ff @(posedge wbm_clk_i or negedge wbm_rst_n_i) begin
    if (!wbm_rst_n_i) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      adr_q   <= '0;
      rem_q   <= '0;
      dat_q   <= '0;
      rdat_q  <= '0;
      rvld_q  <= 1'b0;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      rem_q   <= rem_d;
      dat_q   <= dat_d;
      rdat_q  <= rdat_d;
      rvld_q  <= rvld_d;
      tmr_q   <= tmr_d;
    end
  end
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    adr_d   = adr_q;
    rem_d   = rem_q;
    dat_d   = dat_q;
    rdat_d  = rdat_q;
    rvld_d  = 1'b0;
    tmr_d   = &tmr_q ? tmr_q : tmr_q + TW'(1);
    take    = 1'b0;
    case (state_q)
      IDLE: begin
        tmr_d = '0;
        if (cmd_valid_i) begin
          state_d = REQ;
          we_d    = cmd_we_i;
          adr_d   = cmd_addr_i;
          rem_d   = cmd_len_i;
          take    = cmd_we_i;
          dat_d   = cmd_we_i ? wdat_i : dat_q;
        end
      end
      REQ: begin
        if (wbm_ack_i) begin
          state_d = RELEASE;
          tmr_d   = '0;
          rdat_d  = we_q ? rdat_q : wbm_dat_i;
          rvld_d  = !we_q;
        end else if (tmr_q == TW'(TIMEOUT - 1)) begin
          state_d = ABORT;
        end
      end
      RELEASE: begin
        // the slave keeps ack high until it has seen stb low
        if (!wbm_ack_i) begin
          tmr_d = '0;
          if (rem_q == '0) begin
            state_d = FINISH;
          end else begin
            state_d = REQ;
            rem_d   = rem_q - LEN_WIDTH'(1);
            adr_d   = adr_q + ADDR_WIDTH'(1);
            take    = we_q;
            dat_d   = we_q ? wdat_i : dat_q;
          end
        end else if (tmr_q == TW'(TIMEOUT - 1)) begin
          state_d = ABORT;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  assign cmd_ready_o  = state_q == IDLE;
  assign wdat_take_o  = take & wbm_rst_n_i;
  assign rdat_o       = rdat_q;
  assign rdat_valid_o = rvld_q;
  assign done_o       = state_q == FINISH || state_q == ABORT;
  assign err_o        = state_q == ABORT;
  assign wbm_stb_o    = state_q == REQ;
  assign wbm_cyc_o    = state_q == REQ || state_q == RELEASE;
  assign wbm_we_o     = we_q & wbm_cyc_o;
  assign wbm_sel_o    = {4{wbm_stb_o}};
  assign wbm_adr_o    = adr_q;
  assign wbm_dat_o    = dat_q;
endmodule

// File: tb/tb_wbm_seq.sv
// tb_wbm_seq: scoreboard bench for wbm_seq against a behavioural Wishbone
// slave with configurable ack delay, missing ack and stuck ack.
module tb_wbm_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
  logic [7:0]  cmd_addr = '0, cmd_len = '0;
  logic [31:0] wdat_i, rdat;
  logic        wdat_take, rdat_valid, done, err;
  logic        cyc, stb, we, ack;
  logic [3:0]  sel;
  logic [7:0]  adr;
  logic [31:0] dat_o, dat_i;
  always #5 clk = ~clk;
  wbm_seq dut (
    .wbm_clk_i(clk), .wbm_rst_n_i(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
    .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len),
    .wdat_i(wdat_i), .wdat_take_o(wdat_take),
    .rdat_o(rdat), .rdat_valid_o(rdat_valid), .done_o(done), .err_o(err),
    .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_sel_o(sel),
    .wbm_adr_o(adr), .wbm_dat_o(dat_o), .wbm_dat_i(dat_i), .wbm_ack_i(ack)
  );
  int n_chk = 0, n_err = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask
  // slave: mode 0 normal, 1 never acks, 2 ack stuck high after stb drops
  int mode = 0, dly = 0, scnt = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack  <= 1'b0;
      scnt <= 0;
    end else if (stb) begin
      if (!ack) begin
        if (mode != 1 && scnt >= dly) ack <= 1'b1;
        scnt <= scnt + 1;
      end
    end else begin
      scnt <= 0;
      if (mode != 2) ack <= 1'b0;
    end
  end
  assign dat_i = {24'b0, adr} + 32'h100;
  logic [31:0] wdata [0:63];
  int widx = 0;
  assign wdat_i = wdata[widx];
  always @(posedge clk) if (wdat_take) widx <= widx + 1;
  logic [40:0] bq [$];
  logic [31:0] rq [$];
  logic        dq [$];
  int takes = 0, rvs = 0, dones = 0, beats = 0, rises = 0;
  int srun = 0, last_srun = 0, rrun = 0, last_rrun = 0;
  logic stb_prev = 1'b0;
  always @(negedge clk) begin
    if (stb) srun++; else if (srun > 0) begin last_srun = srun; srun = 0; end
    if (cyc && !stb) rrun++; else if (rrun > 0) begin last_rrun = rrun; rrun = 0; end
    if (stb && !stb_prev) rises++;
    stb_prev = stb;
    if (wdat_take) takes++;
    if (done) begin
      dones++;
      chk("done_expected", dq.size() != 0, 1);
      if (dq.size() != 0) chk("err", err, dq.pop_front());
      chk("done_cyc", cyc, 0);
    end
    if (rdat_valid) begin
      rvs++;
      chk("rdat_expected", rq.size() != 0, 1);
      if (rq.size() != 0) chk("rdat", rdat, rq.pop_front());
    end
    if (stb && ack) begin
      logic [40:0] e;
      beats++;
      chk("beat_expected", bq.size() != 0, 1);
      chk("sel", sel, 4'hF);
      if (bq.size() != 0) begin
        e = bq.pop_front();
        chk("beat_we", we, e[40]);
        chk("beat_adr", adr, e[39:32]);
        if (e[40]) chk("beat_dat", dat_o, e[31:0]);
      end
    end
  end
  task automatic clr();
    takes = 0; rvs = 0; dones = 0; beats = 0; rises = 0;
  endtask
  task automatic cmd(input logic w, input logic [7:0] a, input logic [7:0] l);
    int n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
    chk("cmd_ready", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_we = w; cmd_addr = a; cmd_len = l;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask
  task automatic wait_done(input int bound);
    int n = 0, d0 = dones;
    while (dones == d0 && n < bound) begin @(negedge clk); n++; end
    chk("done_seen", dones != d0, 1);
    @(posedge clk);
  endtask
  task automatic push_rd(input logic [7:0] a, input int n);
    for (int i = 0; i < n; i++) begin
      logic [7:0] x;
      x = a + 8'(i);
      bq.push_back({1'b0, x, 32'h0});
      rq.push_back({24'b0, x} + 32'h100);
    end
  endtask
  initial begin
    for (int i = 0; i < 64; i++) wdata[i] = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_cyc", cyc, 0);
    chk("rst_stb", stb, 0);
    chk("rst_done", done, 0);
    chk("rst_rvld", rdat_valid, 0);
    chk("rst_ready", cmd_ready, 1);
    rst_n = 1'b1;
    // single write with 3-cycle slave latency
    clr(); mode = 0; dly = 3;
    wdata[widx] = 32'hDEADBEEF;
    bq.push_back({1'b1, 8'h10, 32'hDEADBEEF});
    dq.push_back(1'b0);
    cmd(1'b1, 8'h10, 8'd0);
    wait_done(100);
    chk("w1_takes", takes, 1);
    chk("w1_stb_pulses", rises, 1);
    // read burst, zero wait states
    clr(); dly = 0;
    push_rd(8'h20, 4); dq.push_back(1'b0);
    cmd(1'b0, 8'h20, 8'd3);
    wait_done(100);
    chk("rb_rvalid", rvs, 4);
    chk("rb_stb_pulses", rises, 4);
    chk("rb_dones", dones, 1);
    // address wrap
    clr();
    push_rd(8'hFE, 3); dq.push_back(1'b0);
    cmd(1'b0, 8'hFE, 8'd2);
    wait_done(100);
    chk("wrap_beats", beats, 3);
    // ack never arrives
    clr(); mode = 1;
    dq.push_back(1'b1);
    cmd(1'b0, 8'h40, 8'd3);
    wait_done(200);
    chk("to_stb_len", last_srun, 64);
    chk("to_rvalid", rvs, 0);
    clr(); mode = 0;
    push_rd(8'h50, 1); dq.push_back(1'b0);
    cmd(1'b0, 8'h50, 8'd0);
    wait_done(100);
    chk("after_to_rvalid", rvs, 1);
    // ack stuck high after stb drops
    clr(); mode = 2;
    push_rd(8'h60, 1); dq.push_back(1'b1);
    cmd(1'b0, 8'h60, 8'd1);
    wait_done(200);
    chk("stuck_rel_len", last_rrun, 64);
    chk("stuck_beats", beats, 1);
    mode = 0;
    repeat (3) @(negedge clk);
    // async reset during beat 2 of an 8-beat read
    clr();
    push_rd(8'h70, 8); dq.push_back(1'b0);
    cmd(1'b0, 8'h70, 8'd7);
    begin
      int n = 0;
      while (!(stb && beats >= 1) && n < 100) begin @(negedge clk); n++; end
      chk("rst_reach_beat2", stb && beats >= 1, 1);
    end
    #2 rst_n = 1'b0;
    #1;
    chk("arst_cyc", cyc, 0);
    chk("arst_stb", stb, 0);
    begin
      int d0 = dones;
      repeat (3) @(negedge clk);
      chk("arst_no_done", dones, d0);
    end
    bq.delete(); rq.delete(); dq.delete();
    rst_n = 1'b1;
    #1 chk("arst_ready", cmd_ready, 1);
    // fresh 2-beat write after reset
    clr();
    wdata[widx] = 32'h11111111;
    wdata[widx + 1] = 32'h22222222;
    bq.push_back({1'b1, 8'h30, 32'h11111111});
    bq.push_back({1'b1, 8'h31, 32'h22222222});
    dq.push_back(1'b0);
    cmd(1'b1, 8'h30, 8'd1);
    wait_done(100);
    chk("w2_takes", takes, 2);
    chk("w2_beats", beats, 2);
    repeat (2) @(negedge clk);
    chk("bq_left", bq.size(), 0);
    chk("rq_left", rq.size(), 0);
    chk("dq_left", dq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/wbm_seq.md
Name: wbm_seq

Overview:
- Wishbone master sequencer, one clock domain.
- Accepts single or burst read/write commands from fabric logic and issues Wishbone classic cycles to one slave.
- Sits opposite the team's wishbone-fronted BRAM and register slaves.
- Handles the slave's ack-held-until-stb-drops handshake and guards every beat with a timeout.

Parameters:
- DATA_WIDTH, 32, Wishbone data width.
- ADDR_WIDTH, 8, Wishbone word address width.
- LEN_WIDTH, 8, width of burst length field; beats = cmd_len+1.
- TIMEOUT, 64, max cycles waited for ack assert or ack release per beat (>=2).

Ports:
- wbm_clk_i, in, 1, clock.
- wbm_rst_n_i, in, 1, asynchronous active-low reset.
- cmd_valid_i, in, 1, command present.
- cmd_ready_o, out, 1, block idle, command accepted when valid&ready.
- cmd_we_i, in, 1, 1=write burst, 0=read burst.
- cmd_addr_i, in, ADDR_WIDTH, start word address.
- cmd_len_i, in, LEN_WIDTH, beats minus one.
- wdat_i, in, DATA_WIDTH, write data for the current beat.
- wdat_take_o, out, 1, pulse: wdat_i sampled this cycle; next beat's data must be valid by the next take.
- rdat_o, out, DATA_WIDTH, read data.
- rdat_valid_o, out, 1, one-cycle pulse per read beat, no backpressure.
- done_o, out, 1, one-cycle pulse at command end.
- err_o, out, 1, valid with done_o: 1 = timeout abort.
- wbm_cyc_o, out, 1, Wishbone cycle.
- wbm_stb_o, out, 1, Wishbone strobe.
- wbm_we_o, out, 1, Wishbone write enable.
- wbm_sel_o, out, 4, byte selects, constant 4'hF while stb high, else 0.
- wbm_adr_o, out, ADDR_WIDTH, Wishbone address.
- wbm_dat_o, out, DATA_WIDTH, Wishbone write data.
- wbm_dat_i, in, DATA_WIDTH, Wishbone read data.
- wbm_ack_i, in, 1, Wishbone ack.

Behaviour:
- Reset (async, wbm_rst_n_i=0):
  - Immediately drives all outputs to 0, except cmd_ready_o, which goes to 1 once in IDLE.
  - Reset mid-burst drops cyc/stb at once, with no done_o.
  - All registers update on the rising edge of wbm_clk_i.
- State IDLE:
  - cmd_ready_o=1.
  - On cmd_valid_i: latch we, addr, len into remaining-beat counter; go to REQ.
  - For writes, wdat_take_o pulses in the accept cycle and wdat_i is registered onto wbm_dat_o.
- State REQ:
  - cyc=stb=1; we and adr driven from latched values; timer counts from 0.
  - On wbm_ack_i=1:
    - Read beat: capture wbm_dat_i to rdat_o and pulse rdat_valid_o next cycle.
    - Drop stb (cyc stays high); go to RELEASE.
  - If the timer reaches TIMEOUT-1 without ack, go to ABORT.
- State RELEASE:
  - stb=0, cyc=1, timer restarted.
  - Wait for wbm_ack_i=0. This is needed because the slave holds ack until it sees stb low.
  - When ack is low:
    - If remaining=0: go to FINISH.
    - Otherwise: decrement remaining, adr=adr+1 (wraps modulo 2^ADDR_WIDTH, e.g. 0xFF->0x00), then go to REQ. Writes pulse wdat_take_o and load the new wdat_i in the same cycle.
  - Ack still high after TIMEOUT cycles: go to ABORT.
- State FINISH:
  - cyc=0; done_o=1, err_o=0 for one cycle; go to IDLE.
- State ABORT:
  - cyc=stb=0; done_o=1, err_o=1 for one cycle; remaining beats discarded; go to IDLE.
  - No rdat_valid_o for the failed beat.
- Ack observed while stb=0 in IDLE: ignored.
- Minimum per-beat cost: REQ(>=1)+RELEASE(>=1) cycles. A zero-wait-state slave gives 2 cycles/beat plus 1 FINISH cycle.
- cmd_ready_o=0 in all states except IDLE. A command presented in the FINISH cycle is accepted on the following cycle.
- Timer width = clog2(TIMEOUT)+1. It saturates and never wraps.

Test Plan:
- Single write: addr 0x10, len 0, wdat 0xDEADBEEF, slave acks after 3 cycles, holds ack until stb low → one stb pulse with adr 0x10, we=1, dat 0xDEADBEEF, sel 0xF; one wdat_take_o; done_o=1, err_o=0.
- Read burst: addr 0x20, len 3, slave returns addr+0x100 → four rdat_valid_o pulses with 0x120..0x123; stb deasserts between beats; done_o once.
- Address wrap: read addr 0xFE, len 2 → wbm_adr_o sequence 0xFE, 0xFF, 0x00.
- Timeout: slave never acks, TIMEOUT=64 → stb high exactly 64 cycles, then cyc=stb=0, done_o=1, err_o=1, no rdat_valid_o; next command accepted.
- Stuck ack: ack held high after stb drop → ABORT after TIMEOUT cycles in RELEASE, err_o=1.
- Async reset mid-burst: assert wbm_rst_n_i=0 during beat 2 of len 7 → cyc/stb low without waiting for a clock edge, no done_o; after release cmd_ready_o=1 and a fresh write completes correctly.
